// File: rtl/prog_loader_pkg.sv
// Shared types for the boot-time program loader: FSM states, byte type and
// the checksum target used when PROG_LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    ADDR  = 3'd3,
    WRITE = 3'd4,
    CHK   = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } state_t;

  typedef logic [7:0] byte_t;

  localparam byte_t CHECKSUM_OK = 8'h00;

endpackage

// File: rtl/prog_loader_if.sv
// Stream-in / bus-out signal bundle of prog_loader. The master side feeds the
// byte stream and start; the slave side (the loader) drives bus, RAM strobes and status.
interface prog_loader_if;
  import prog_loader_pkg::*;

  // Handshake: i_byte moves on a rising edge where i_byteValid & o_byteReady;
  // while valid and not ready the source holds i_byte stable, and valid may drop at any time.
  logic   i_start;
  byte_t  i_byte;
  logic   i_byteValid;
  logic   o_byteReady;
  byte_t  o_busData;
  logic   o_busEn;
  logic   o_ramAddressEn;
  logic   o_ramWriteEn;
  logic   o_cpuHold;
  logic   o_done;
  logic   o_error;
  byte_t  o_count;
  state_t dbgState;

  modport master (
    output i_start, i_byte, i_byteValid,
    input  o_byteReady, o_busData, o_busEn, o_ramAddressEn, o_ramWriteEn,
           o_cpuHold, o_done, o_error, o_count, dbgState
  );

  modport slave (
    input  i_start, i_byte, i_byteValid,
    output o_byteReady, o_busData, o_busEn, o_ramAddressEn, o_ramWriteEn,
           o_cpuHold, o_done, o_error, o_count, dbgState
  );

endinterface

// File: rtl/prog_loader.sv
// Boot loader: takes a length-prefixed byte stream and writes it into program RAM
// over the shared bus (address cycle, then data cycle). Optional trailer check: PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] BASE_ADDR = 8'h00
) (
  input logic          i_clk,
  input logic          i_reset,
  prog_loader_if.slave loadBus
);

  state_t state;
  byte_t  addr;
  byte_t  len;
  byte_t  dataHold;
`ifdef PROG_LOADER_CHECKSUM_EN
  byte_t  sum;
`endif

  logic accept;
  assign accept = loadBus.i_byteValid & loadBus.o_byteReady;

  assign loadBus.dbgState = state;

  // All outputs are registered and updated together with the state they belong to.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state                  <= IDLE;
      addr                   <= BASE_ADDR;
      len                    <= '0;
      dataHold               <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum                    <= '0;
`endif
      loadBus.o_byteReady    <= 1'b0;
      loadBus.o_busData      <= '0;
      loadBus.o_busEn        <= 1'b0;
      loadBus.o_ramAddressEn <= 1'b0;
      loadBus.o_ramWriteEn   <= 1'b0;
      loadBus.o_cpuHold      <= 1'b0;
      loadBus.o_done         <= 1'b0;
      loadBus.o_error        <= 1'b0;
      loadBus.o_count        <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (loadBus.i_start) begin
            state               <= LEN;
            addr                <= BASE_ADDR;
            loadBus.o_cpuHold   <= 1'b1;
            loadBus.o_done      <= 1'b0;
            loadBus.o_error     <= 1'b0;
            loadBus.o_count     <= '0;
            loadBus.o_byteReady <= 1'b1;
          end
        end
        LEN: begin
          if (accept) begin
            if (loadBus.i_byte == 8'h00) begin
              state               <= ERR;
              loadBus.o_byteReady <= 1'b0;
              loadBus.o_cpuHold   <= 1'b0;
              loadBus.o_error     <= 1'b1;
            end else begin
              state <= DATA;
              len   <= loadBus.i_byte;
`ifdef PROG_LOADER_CHECKSUM_EN
              sum   <= loadBus.i_byte;
`endif
            end
          end
        end
        DATA: begin
          if (accept) begin
            state                  <= ADDR;
            dataHold               <= loadBus.i_byte;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum                    <= byte_t'(sum + loadBus.i_byte);
`endif
            loadBus.o_byteReady    <= 1'b0;
            loadBus.o_busEn        <= 1'b1;
            loadBus.o_busData      <= addr;
            loadBus.o_ramAddressEn <= 1'b1;
          end
        end
        ADDR: begin
          state                  <= WRITE;
          loadBus.o_busData      <= dataHold;
          loadBus.o_ramAddressEn <= 1'b0;
          loadBus.o_ramWriteEn   <= 1'b1;
        end
        WRITE: begin
          addr                 <= byte_t'(addr + 8'd1);
          loadBus.o_count      <= byte_t'(loadBus.o_count + 8'd1);
          loadBus.o_ramWriteEn <= 1'b0;
          loadBus.o_busEn      <= 1'b0;
          loadBus.o_busData    <= '0;
          if (byte_t'(loadBus.o_count + 8'd1) == len) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state               <= CHK;
            loadBus.o_byteReady <= 1'b1;
`else
            state               <= DONE;
            loadBus.o_cpuHold   <= 1'b0;
            loadBus.o_done      <= 1'b1;
`endif
          end else begin
            state               <= DATA;
            loadBus.o_byteReady <= 1'b1;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        CHK: begin
          // Written bytes stay in RAM even when the trailer does not match.
          if (accept) begin
            loadBus.o_byteReady <= 1'b0;
            loadBus.o_cpuHold   <= 1'b0;
            if (byte_t'(sum + loadBus.i_byte) == CHECKSUM_OK) begin
              state          <= DONE;
              loadBus.o_done <= 1'b1;
            end else begin
              state           <= ERR;
              loadBus.o_error <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: two loaders (base 00 and FE) each with a small
// two-step RAM model on its bus; expected RAM contents and status are hand-computed.
module tb_prog_loader;
  import prog_loader_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prog_loader_if bus0 ();
  prog_loader_if bus1 ();

  prog_loader #(.BASE_ADDR(8'h00)) dut0 (.i_clk(clk), .i_reset(rst), .loadBus(bus0.slave));
  prog_loader #(.BASE_ADDR(8'hFE)) dut1 (.i_clk(clk), .i_reset(rst), .loadBus(bus1.slave));

  // RAM models and strobe monitors
  byte_t ram0 [256];
  byte_t ram1 [256];
  byte_t ra0 = 8'h00;
  byte_t ra1 = 8'h00;
  int aCnt0 = 0, wCnt0 = 0, aCnt1 = 0, wCnt1 = 0, clash = 0;

  always @(posedge clk) begin
    if (bus0.o_ramAddressEn) begin ra0 <= bus0.o_busData; aCnt0 <= aCnt0 + 1; end
    if (bus0.o_ramWriteEn)   begin ram0[ra0] <= bus0.o_busData; wCnt0 <= wCnt0 + 1; end
    if (bus1.o_ramAddressEn) begin ra1 <= bus1.o_busData; aCnt1 <= aCnt1 + 1; end
    if (bus1.o_ramWriteEn)   begin ram1[ra1] <= bus1.o_busData; wCnt1 <= wCnt1 + 1; end
    if ((bus0.o_ramAddressEn && bus0.o_ramWriteEn) ||
        ((bus0.o_ramAddressEn || bus0.o_ramWriteEn) && !bus0.o_busEn) ||
        (bus1.o_ramAddressEn && bus1.o_ramWriteEn) ||
        ((bus1.o_ramAddressEn || bus1.o_ramWriteEn) && !bus1.o_busEn))
      clash <= clash + 1;
  end

  // scoreboard
  int total = 0;
  int bad   = 0;
  byte_t tbSum;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v, input byte_t b);
    if (sel) begin bus1.i_byteValid = v; bus1.i_byte = b; end
    else     begin bus0.i_byteValid = v; bus0.i_byte = b; end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? bus1.o_byteReady : bus0.o_byteReady;
  endfunction

  function automatic logic fin(input bit sel);
    return sel ? (bus1.o_done | bus1.o_error) : (bus0.o_done | bus0.o_error);
  endfunction

  function automatic logic hold(input bit sel);
    return sel ? bus1.o_cpuHold : bus0.o_cpuHold;
  endfunction

  task automatic startLoad(input bit sel);
    tbSum = 8'h00;
    if (sel) bus1.i_start = 1'b1; else bus0.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus0.i_start = 1'b0;
    bus1.i_start = 1'b0;
  endtask

  task automatic sendByte(input bit sel, input byte_t b);
    int n = 0;
    drive(sel, 1'b1, b);
    tbSum = byte_t'(tbSum + b);
    @(negedge clk);
    while (!rdy(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(rdy(sel)), 32'd1);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 8'h00);
  endtask

  task automatic finishLoad(input bit sel);
`ifdef PROG_LOADER_CHECKSUM_EN
    sendByte(sel, byte_t'(8'h00 - tbSum));
`else
    if (sel) tbSum = tbSum; else tbSum = tbSum;
`endif
  endtask

  task automatic waitEnd(input bit sel, output logic heldBefore);
    int n = 0;
    logic prevHold = 1'b0;
    @(negedge clk);
    while (!fin(sel) && n < 20) begin
      prevHold = hold(sel);
      @(negedge clk);
      n++;
    end
    chk("end_reached", 32'(fin(sel)), 32'd1);
    heldBefore = prevHold;
  endtask

  // directed sequence
  initial begin
    logic hb;
    int a0, w0, a1, w1, rc;
    bus0.i_start = 1'b0; bus0.i_byte = 8'h00; bus0.i_byteValid = 1'b0;
    bus1.i_start = 1'b0; bus1.i_byte = 8'h00; bus1.i_byteValid = 1'b0;

    // reset state
    rst = 1'b1;
    tick(3);
    chk("rst_state", 32'(bus0.dbgState), 32'(IDLE));
    chk("rst_hold",  32'(bus0.o_cpuHold), 32'd0);
    chk("rst_ready", 32'(bus0.o_byteReady), 32'd0);
    chk("rst_busen", 32'(bus0.o_busEn), 32'd0);
    chk("rst_flags", {bus0.o_done, bus0.o_error, bus1.o_done, bus1.o_error}, 32'd0);
    chk("rst_count", 32'(bus0.o_count), 32'd0);
    rst = 1'b0;
    tick(1);

    // basic load at base 00
    a0 = aCnt0; w0 = wCnt0;
    startLoad(0);
    chk("start_hold", 32'(bus0.o_cpuHold), 32'd1);
    chk("start_state", 32'(bus0.dbgState), 32'(LEN));
    sendByte(0, 8'h03); sendByte(0, 8'hA1); sendByte(0, 8'hB2); sendByte(0, 8'hC3);
    finishLoad(0);
    waitEnd(0, hb);
    chk("basic_done", 32'(bus0.o_done), 32'd1);
    chk("basic_hold", 32'(bus0.o_cpuHold), 32'd0);
    chk("basic_hold_until_done", 32'(hb), 32'd1);
    chk("basic_count", 32'(bus0.o_count), 32'd3);
    chk("basic_ram0", 32'(ram0[0]), 32'hA1);
    chk("basic_ram1", 32'(ram0[1]), 32'hB2);
    chk("basic_ram2", 32'(ram0[2]), 32'hC3);
    chk("basic_aen", 32'(aCnt0 - a0), 32'd3);
    chk("basic_wen", 32'(wCnt0 - w0), 32'd3);
    chk("basic_busen", 32'(bus0.o_busEn), 32'd0);

    // wrap at base FE
    a1 = aCnt1; w1 = wCnt1;
    startLoad(1);
    sendByte(1, 8'h03); sendByte(1, 8'h11); sendByte(1, 8'h22); sendByte(1, 8'h33);
    finishLoad(1);
    waitEnd(1, hb);
    chk("wrap_done", 32'(bus1.o_done), 32'd1);
    chk("wrap_ramFE", 32'(ram1[8'hFE]), 32'h11);
    chk("wrap_ramFF", 32'(ram1[8'hFF]), 32'h22);
    chk("wrap_ram00", 32'(ram1[8'h00]), 32'h33);
    chk("wrap_wen", 32'(wCnt1 - w1), 32'd3);

    // zero length, then recovery
    a0 = aCnt0; w0 = wCnt0;
    startLoad(0);
    chk("zero_done_cleared", 32'(bus0.o_done), 32'd0);
    sendByte(0, 8'h00);
    waitEnd(0, hb);
    chk("zero_error", 32'(bus0.o_error), 32'd1);
    chk("zero_done", 32'(bus0.o_done), 32'd0);
    chk("zero_hold", 32'(bus0.o_cpuHold), 32'd0);
    chk("zero_strobes", 32'((aCnt0 - a0) + (wCnt0 - w0)), 32'd0);
    chk("zero_state", 32'(bus0.dbgState), 32'(ERR));
    startLoad(0);
    chk("retry_err_cleared", 32'(bus0.o_error), 32'd0);
    sendByte(0, 8'h01); sendByte(0, 8'h5A);
    finishLoad(0);
    waitEnd(0, hb);
    chk("retry_done", 32'(bus0.o_done), 32'd1);
    chk("retry_ram", 32'(ram0[0]), 32'h5A);
    chk("retry_count", 32'(bus0.o_count), 32'd1);

    // stall between data bytes, with a stray start pulse
    startLoad(0);
    sendByte(0, 8'h02); sendByte(0, 8'h44);
    tick(3);
    a0 = aCnt0; w0 = wCnt0; rc = 0;
    for (int i = 0; i < 10; i++) begin
      bus0.i_start = (i == 4);
      @(negedge clk);
      if (bus0.o_byteReady) rc++;
      @(posedge clk);
      #1;
    end
    bus0.i_start = 1'b0;
    chk("stall_ready", 32'(rc), 32'd10);
    chk("stall_strobes", 32'((aCnt0 - a0) + (wCnt0 - w0)), 32'd0);
    chk("stall_state", 32'(bus0.dbgState), 32'(DATA));
    chk("stall_count", 32'(bus0.o_count), 32'd1);
    sendByte(0, 8'h55);
    finishLoad(0);
    waitEnd(0, hb);
    chk("stall_done", 32'(bus0.o_done), 32'd1);
    chk("stall_ram0", 32'(ram0[0]), 32'h44);
    chk("stall_ram1", 32'(ram0[1]), 32'h55);
    chk("stall_count_end", 32'(bus0.o_count), 32'd2);

    // reset in WRITE of byte 2 of 5
    startLoad(0);
    sendByte(0, 8'h05); sendByte(0, 8'h01); sendByte(0, 8'h02);
    tick(1);
    chk("mid_in_write", 32'(bus0.dbgState), 32'(WRITE));
    chk("mid_wen", 32'(bus0.o_ramWriteEn), 32'd1);
    rst = 1'b1;
    tick(1);
    a0 = aCnt0; w0 = wCnt0;
    chk("mid_state", 32'(bus0.dbgState), 32'(IDLE));
    chk("mid_outputs", {bus0.o_cpuHold, bus0.o_done, bus0.o_error, bus0.o_busEn,
                        bus0.o_ramAddressEn, bus0.o_ramWriteEn, bus0.o_byteReady}, 32'd0);
    chk("mid_bus", {bus0.o_busData, bus0.o_count}, 32'd0);
    rst = 1'b0;
    tick(5);
    chk("mid_no_strobes", 32'((aCnt0 - a0) + (wCnt0 - w0)), 32'd0);
    chk("mid_idle", 32'(bus0.dbgState), 32'(IDLE));

`ifdef PROG_LOADER_CHECKSUM_EN
    // bad trailer: bytes stay written
    startLoad(0);
    sendByte(0, 8'h02); sendByte(0, 8'h10); sendByte(0, 8'h20); sendByte(0, 8'hCF);
    waitEnd(0, hb);
    chk("cks_bad_error", 32'(bus0.o_error), 32'd1);
    chk("cks_bad_done", 32'(bus0.o_done), 32'd0);
    chk("cks_bad_ram0", 32'(ram0[0]), 32'h10);
    chk("cks_bad_ram1", 32'(ram0[1]), 32'h20);
    // good trailer
    startLoad(0);
    sendByte(0, 8'h02); sendByte(0, 8'h10); sendByte(0, 8'h20); sendByte(0, 8'hCE);
    waitEnd(0, hb);
    chk("cks_ok_done", 32'(bus0.o_done), 32'd1);
    chk("cks_ok_error", 32'(bus0.o_error), 32'd0);
`endif

    chk("strobe_rules", 32'(clash), 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time writer for the 8-bit shared-bus CPU.
- Accepts a length-prefixed byte stream over a valid/ready handshake.
- While it holds the CPU, it becomes the sole bus driver and writes each byte into program RAM. It uses the RAM's two-step bus protocol: an address-latch cycle, then a write-data cycle.
- When the image is complete, it releases the CPU and leaves the bus tri-state so the CPU can fetch from address BASE_ADDR.

Parameters:
- BASE_ADDR, 8'h00, RAM address of the first loaded byte; later bytes go to consecutive addresses, wrapping modulo 256.
- DATA_W, 8, bus, RAM address and RAM data width; fixed at 8 for this CPU.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_start  in  1  begin a load; sampled only in IDLE, DONE or ERR.
- i_byte  in  8  stream byte.
- i_byteValid  in  1  i_byte is valid.
- o_byteReady  out  1  loader accepts i_byte this cycle.
- o_busData  out  8  value the loader drives onto the shared bus.
- o_busEn  out  1  loader output-enable onto the bus; all other bus drivers must be off while o_cpuHold=1.
- o_ramAddressEn  out  1  RAM latches the bus as its address.
- o_ramWriteEn  out  1  RAM writes the bus into the latched address.
- o_cpuHold  out  1  holds the CPU control unit in reset.
- o_done  out  1  load completed successfully.
- o_error  out  1  load aborted.
- o_count  out  8  data bytes written so far in the current load.

Behaviour:
- Clock and reset: single clock i_clk; i_reset is synchronous and active-high.
- Reset values: state IDLE; all outputs 0; internal address BASE_ADDR; length 0; checksum 0. Reset mid-load aborts immediately: no further RAM strobes, o_cpuHold drops on the next edge.
- Handshake: a byte transfers on a rising edge where i_byteValid & o_byteReady. o_byteReady is 1 only in LEN, DATA and CHK. i_byte must be held stable while valid and not ready.
- State IDLE / DONE / ERR:
  - i_start=1 -> LEN; o_cpuHold=1; o_done, o_error and o_count cleared; address reset to BASE_ADDR.
  - i_start is ignored in every other state.
- State LEN: accept length N.
  - N=0 -> ERR.
  - Otherwise store N -> DATA.
- State DATA: accept data byte D into a holding register -> ADDR.
- State ADDR: one cycle; o_busEn=1, o_busData=addr, o_ramAddressEn=1 -> WRITE.
- State WRITE: one cycle; o_busEn=1, o_busData=D, o_ramWriteEn=1.
  - On exit: addr <= addr+1 (8-bit wrap, 8'hFF -> 8'h00); o_count increments.
  - If o_count+1 == N -> DONE (or CHK when the checksum feature is compiled in); else -> DATA.
- State DONE: o_cpuHold=0, o_busEn=0, o_done=1 held until next i_start or reset.
- State ERR: o_cpuHold=0, o_busEn=0, o_error=1 held until next i_start or reset.
- Strobes: o_ramAddressEn and o_ramWriteEn are never high together and are never high outside ADDR/WRITE. o_busEn=1 only in ADDR and WRITE.
- Throughput: minimum 3 cycles per data byte (DATA accept, ADDR, WRITE). A valid held continuously yields o_byteReady=1 every third cycle.
- o_cpuHold: high from the edge leaving IDLE/DONE/ERR until entering DONE or ERR.
- Stall: i_byteValid may drop at any time; the loader waits in LEN, DATA or CHK indefinitely with no timeout.
- Length range: N up to 255. Address wrap past 8'hFF is legal and silent.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit accumulator sums N and every data byte (modulo 256).
  - After the last WRITE, the FSM enters CHK and accepts one trailer byte C.
  - (sum + C) == 8'h00 -> DONE; otherwise -> ERR.
  - Bytes already written are not rolled back on ERR.
- Undefined: no CHK state and no accumulator; the last WRITE goes directly to DONE.

Decomposition:
- Package prog_loader_pkg holds:
  - state enum: IDLE, LEN, DATA, ADDR, WRITE, CHK, DONE, ERR, 3-bit encoding;
  - byte type typedef (8-bit logic);
  - constant CHECKSUM_OK = 8'h00.
- Single module with no sub-module. The FSM, address counter, byte counter and checksum accumulator are each small; the bus drive is pure decode of state.

Test Plan:
- Basic load: BASE_ADDR=0, stream 03,A1,B2,C3 with valid always high -> RAM[0..2]=A1,B2,C3; exactly 3 o_ramAddressEn and 3 o_ramWriteEn pulses, each one cycle; o_done=1; o_cpuHold falls the same edge o_done rises; o_count=3.
- Wrap: BASE_ADDR=8'hFE, stream 03,11,22,33 -> RAM[FE]=11, RAM[FF]=22, RAM[00]=33; o_done=1.
- Zero length: stream 00 -> o_error=1, no RAM strobes, o_cpuHold=0. A subsequent i_start with 01,5A -> RAM[BASE]=5A, o_error cleared, o_done=1.
- Backpressure / stall: drop i_byteValid for 10 cycles between data bytes -> no strobes while stalled, o_byteReady stays 1 in DATA, final RAM contents correct. Pulsing i_start mid-load has no effect.
- Reset mid-load: assert i_reset while in WRITE of byte 2 of 5 -> next cycle all outputs 0, state IDLE, no further strobes.
- With PROG_LOADER_CHECKSUM_EN:
  - 02,10,20,CE (sum 02+10+20+CE = 0x100 -> 00) -> o_done=1.
  - Trailer CF instead -> o_error=1, RAM[BASE..BASE+1]=10,20 still written.
